// File: rtl/snake_pkg.sv
// Shared encodings for the snake engine: headings, FSM states, default colours.
// Opposite headings differ only in bit 0, which the reversal check relies on.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_ERASE = 3'd3,
        ST_DRAW  = 3'd4
    } state_e;

    localparam logic [2:0] HEAD_COL_DEF = 3'b001;
    localparam logic [2:0] BG_COL_DEF   = 3'b111;

    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
        return req == (cur ^ 2'd1);
    endfunction

endpackage

// File: rtl/snake_seg_ring.sv
// Body segment store: one synchronous write port and one registered read port.
// A read during a write to the same address returns the old contents.
module snake_seg_ring #(
    parameter int DEPTH = 128,
    parameter int DW    = 15,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement engine: advances the head per step, checks walls and the body
// one segment per cycle, then streams erase-tail / draw-head pixels to the plotter.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int         MAX_LEN  = 128,
    parameter int         XW       = 8,
    parameter int         YW       = 7,
    parameter int         X_MIN    = 48,
    parameter int         X_MAX    = 112,
    parameter int         Y_MIN    = 28,
    parameter int         Y_MAX    = 92,
    parameter int         INIT_X   = 80,
    parameter int         INIT_Y   = 60,
    parameter logic [2:0] HEAD_COL = HEAD_COL_DEF,
    parameter logic [2:0] BG_COL   = BG_COL_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     restart,
    input  logic                     step,
    input  logic [1:0]               dir,
    input  logic                     grow,
    output logic [XW-1:0]            px_x,
    output logic [YW-1:0]            px_y,
    output logic [2:0]               px_colour,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [XW-1:0]            head_x,
    output logic [YW-1:0]            head_y,
    output logic [$clog2(MAX_LEN):0] length,
    output logic                     busy,
    output logic                     over
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam int SW = XW + YW;

    localparam logic [XW-1:0] INIT_X_L = XW'(INIT_X);
    localparam logic [YW-1:0] INIT_Y_L = YW'(INIT_Y);
    localparam logic [XW:0]   X_MIN_L  = (XW+1)'(X_MIN);
    localparam logic [XW:0]   X_MAX_L  = (XW+1)'(X_MAX);
    localparam logic [YW:0]   Y_MIN_L  = (YW+1)'(Y_MIN);
    localparam logic [YW:0]   Y_MAX_L  = (YW+1)'(Y_MAX);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    state_e        state_q, state_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic [XW-1:0] next_x_q, next_x_d;
    logic [YW-1:0] next_y_q, next_y_d;
    logic [1:0]    heading_q, heading_d;
    logic          grow_q, grow_d;
    logic          over_q, over_d;
    logic [LW-1:0] len_q, len_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] scan_q, scan_d;

    logic          ring_we;
    logic [PW-1:0] ring_waddr;
    logic [SW-1:0] ring_wdata;
    logic [PW-1:0] ring_raddr;
    logic [SW-1:0] ring_rdata;

    snake_seg_ring #(
        .DEPTH (MAX_LEN),
        .DW    (SW),
        .AW    (PW)
    ) u_ring (
        .clk     (clk),
        .we_i    (ring_we),
        .waddr_i (ring_waddr),
        .wdata_i (ring_wdata),
        .raddr_i (ring_raddr),
        .rdata_o (ring_rdata)
    );

    // Candidate head one bit wider so that stepping below zero reads as out of range.
    logic [XW:0]   hx_ext, cand_x;
    logic [YW:0]   hy_ext, cand_y;
    logic          out_of_bounds;
    logic          step_ok;
    logic [LW-1:0] scan_n;
    logic [LW-1:0] scan_nxt;
    logic          scan_last;
    logic          seg_hit;
    logic [PW-1:0] tail_idx;

    assign hx_ext = {1'b0, head_x_q};
    assign hy_ext = {1'b0, head_y_q};
    assign cand_x = (heading_q == DIR_L) ? hx_ext - (XW+1)'(1) :
                    (heading_q == DIR_R) ? hx_ext + (XW+1)'(1) : hx_ext;
    assign cand_y = (heading_q == DIR_U) ? hy_ext - (YW+1)'(1) :
                    (heading_q == DIR_D) ? hy_ext + (YW+1)'(1) : hy_ext;
    assign out_of_bounds = (cand_x < X_MIN_L) || (cand_x > X_MAX_L) ||
                           (cand_y < Y_MIN_L) || (cand_y > Y_MAX_L);

    assign step_ok   = step && (state_q == ST_IDLE) && !over_q;
    assign scan_n    = grow_q ? len_q : len_q - LW'(1);
    assign scan_nxt  = scan_q + LW'(1);
    assign scan_last = (scan_nxt >= scan_n);
    assign seg_hit   = (scan_q < scan_n) && (ring_rdata == {next_x_q, next_y_q});
    // A full ring makes len wrap to zero in PW bits, giving tail = ptr+1 as required.
    assign tail_idx  = ptr_q - len_q[PW-1:0] + PW'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            head_x_q  <= INIT_X_L;
            head_y_q  <= INIT_Y_L;
            next_x_q  <= '0;
            next_y_q  <= '0;
            heading_q <= DIR_R;
            grow_q    <= 1'b0;
            over_q    <= 1'b0;
            len_q     <= LW'(1);
            ptr_q     <= '0;
            scan_q    <= '0;
        end else begin
            state_q   <= state_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            heading_q <= heading_d;
            grow_q    <= grow_d;
            over_q    <= over_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            scan_q    <= scan_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        heading_d = heading_q;
        grow_d    = grow_q;
        over_d    = over_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        scan_d    = scan_q;

        unique case (state_q)
            ST_IDLE: begin
                if (step_ok) begin
                    state_d = ST_CALC;
                    grow_d  = grow && (len_q != MAX_LEN_L);
                    if (!is_reverse(dir, heading_q)) begin
                        heading_d = dir;
                    end
                end
            end
            ST_CALC: begin
                if (out_of_bounds) begin
                    over_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    next_x_d = cand_x[XW-1:0];
                    next_y_d = cand_y[YW-1:0];
                    scan_d   = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (seg_hit) begin
                    over_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (scan_last) begin
                    state_d = grow_q ? ST_DRAW : ST_ERASE;
                end else begin
                    scan_d = scan_nxt;
                end
            end
            ST_ERASE: begin
                if (px_ready) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (px_ready) begin
                    head_x_d = next_x_q;
                    head_y_d = next_y_q;
                    ptr_d    = ptr_q + PW'(1);
                    len_d    = len_q + LW'(grow_q);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart) begin
            state_d   = ST_IDLE;
            head_x_d  = INIT_X_L;
            head_y_d  = INIT_Y_L;
            heading_d = DIR_R;
            grow_d    = 1'b0;
            over_d    = 1'b0;
            len_d     = LW'(1);
            ptr_d     = '0;
            scan_d    = '0;
        end
    end

    // Read address runs one cycle ahead of the compare; the last scan cycle fetches the tail.
    always_comb begin
        px_valid   = 1'b0;
        px_x       = '0;
        px_y       = '0;
        px_colour  = '0;
        ring_raddr = tail_idx;
        ring_we    = 1'b0;
        ring_waddr = '0;
        ring_wdata = '0;

        unique case (state_q)
            ST_CALC: begin
                ring_raddr = ptr_q;
            end
            ST_SCAN: begin
                if (scan_nxt < scan_n) begin
                    ring_raddr = ptr_q - scan_nxt[PW-1:0];
                end
            end
            ST_ERASE: begin
                px_valid  = 1'b1;
                px_x      = ring_rdata[SW-1:YW];
                px_y      = ring_rdata[YW-1:0];
                px_colour = BG_COL;
            end
            ST_DRAW: begin
                px_valid  = 1'b1;
                px_x      = next_x_q;
                px_y      = next_y_q;
                px_colour = HEAD_COL;
            end
            default: begin
            end
        endcase

        // The reset head must live in the ring so the first tail erase finds it.
        if (!resetn || restart) begin
            ring_we    = 1'b1;
            ring_waddr = '0;
            ring_wdata = {INIT_X_L, INIT_Y_L};
        end else if (state_q == ST_DRAW && px_ready) begin
            ring_we    = 1'b1;
            ring_waddr = ptr_q + PW'(1);
            ring_wdata = {next_x_q, next_y_q};
        end
    end

    assign head_x = head_x_q;
    assign head_y = head_y_q;
    assign length = len_q;
    assign busy   = (state_q != ST_IDLE);
    assign over   = over_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Randomised bench for snake_body_engine, checked against a queue-based body model.
// Pixels are words {x,y,colour}; each step's handshakes are compared as a packed list.
module tb_snake_body_engine;

    localparam int MAX_LEN = 128;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       restart = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir = 2'd1;
    logic       grow = 1'b0;
    logic       px_ready = 1'b1;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;
    logic       px_valid;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [7:0] length;
    logic       busy;
    logic       over;

    snake_body_engine dut (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart),
        .step      (step),
        .dir       (dir),
        .grow      (grow),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_colour (px_colour),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .busy      (busy),
        .over      (over)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int step_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] obs_px[$];
    int          obs_edge[$];

    always @(negedge clk) begin
        if (px_valid && px_ready) begin
            obs_px.push_back({px_x, px_y, px_colour});
            obs_edge.push_back(cyc + 1);
        end
    end

    // Reference model: body as a coordinate queue, head at the front.
    int          m_x[$];
    int          m_y[$];
    int          m_head;
    bit          m_over;
    logic [17:0] exp_px[$];

    task automatic model_reset();
        m_x.delete(); m_y.delete();
        m_x.push_back(80); m_y.push_back(60);
        m_head = 1;
        m_over = 0;
        exp_px.delete();
    endtask

    task automatic model_step(input int d, input bit g);
        int nx, ny, n;
        bit gg, hit;
        exp_px.delete();
        if (m_over) return;
        if (d != (m_head ^ 1)) m_head = d;
        gg = g && (m_x.size() < MAX_LEN);
        nx = m_x[0]; ny = m_y[0];
        case (m_head)
            0: nx = nx - 1;
            1: nx = nx + 1;
            2: ny = ny - 1;
            default: ny = ny + 1;
        endcase
        if (nx < 48 || nx > 112 || ny < 28 || ny > 92) begin
            m_over = 1;
            return;
        end
        n = gg ? m_x.size() : m_x.size() - 1;
        hit = 0;
        for (int i = 0; i < n; i++) if (m_x[i] == nx && m_y[i] == ny) hit = 1;
        if (hit) begin
            m_over = 1;
            return;
        end
        if (!gg) begin
            exp_px.push_back({8'(m_x[m_x.size()-1]), 7'(m_y[m_y.size()-1]), 3'b111});
            void'(m_x.pop_back());
            void'(m_y.pop_back());
        end
        m_x.push_front(nx); m_y.push_front(ny);
        exp_px.push_back({8'(nx), 7'(ny), 3'b001});
    endtask

    function automatic logic [39:0] obs_word();
        return {4'(obs_px.size()), (obs_px.size() > 0) ? obs_px[0] : 18'd0,
                (obs_px.size() > 1) ? obs_px[1] : 18'd0};
    endfunction

    function automatic logic [39:0] exp_word();
        return {4'(exp_px.size()), (exp_px.size() > 0) ? exp_px[0] : 18'd0,
                (exp_px.size() > 1) ? exp_px[1] : 18'd0};
    endfunction

    function automatic logic [23:0] model_state();
        return {8'(m_x[0]), 7'(m_y[0]), 8'(m_x.size()), 1'(m_over)};
    endfunction

    task automatic do_step(input int d, input bit g, input bit rnd, output bit ok);
        obs_px.delete(); obs_edge.delete();
        @(posedge clk); #1;
        dir = 2'(d); grow = g; step = 1'b1; step_edge = cyc + 1;
        @(posedge clk); #1;
        step = 1'b0; grow = 1'b0;
        if (rnd) px_ready = 1'($urandom_range(0, 1));
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) px_ready = 1'($urandom_range(0, 1));
        end
        px_ready = 1'b1;
    endtask

    task automatic do_restart();
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        @(negedge clk);
        chk_cnt++;
        if ({head_x, head_y} !== {8'd80, 7'd60})
            $display("FAIL reset_head: got (%0d,%0d) want (80,60)", head_x, head_y);
        else pass_cnt++;
        chk_cnt++;
        if ({length, busy, over} !== {8'd1, 1'b0, 1'b0})
            $display("FAIL reset_flags: got len=%0d busy=%b over=%b want 1/0/0", length, busy, over);
        else pass_cnt++;
        chk_cnt++;
        if ({px_valid, px_x, px_y, px_colour} !== 19'd0)
            $display("FAIL reset_pixel: got v=%b (%0d,%0d) c=%0d want all zero", px_valid, px_x, px_y, px_colour);
        else pass_cnt++;
    endtask

    task automatic test_straight();
        bit ok;
        for (int s = 0; s < 3; s++) begin
            do_step(1, 0, 0, ok);
            model_step(1, 0);
            chk_cnt++;
            if (ok !== 1'b1) $display("FAIL straight_timeout: step %0d got busy stuck want idle", s);
            else pass_cnt++;
            chk_cnt++;
            if (obs_word() !== exp_word())
                $display("FAIL straight_px: step %0d got %h want %h", s, obs_word(), exp_word());
            else pass_cnt++;
            chk_cnt++;
            if (obs_edge.size() != 2 || (obs_edge[0] - step_edge) != 3 || (obs_edge[1] - step_edge) != 4)
                $display("FAIL straight_latency: step %0d got %0d handshakes, first at +%0d want +3/+4",
                         s, obs_edge.size(), (obs_edge.size() > 0) ? obs_edge[0] - step_edge : -1);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({head_x, head_y, length} !== {8'd83, 7'd60, 8'd1})
            $display("FAIL straight_end: got (%0d,%0d) len=%0d want (83,60) len=1", head_x, head_y, length);
        else pass_cnt++;
    endtask

    task automatic test_wall();
        bit ok;
        do_restart();
        for (int s = 0; s < 32; s++) begin
            do_step(1, 0, 0, ok);
            model_step(1, 0);
            chk_cnt++;
            if (obs_word() !== exp_word())
                $display("FAIL wall_walk_px: step %0d got %h want %h", s, obs_word(), exp_word());
            else pass_cnt++;
        end
        do_step(1, 0, 0, ok);
        model_step(1, 0);
        chk_cnt++;
        if ({over, 4'(obs_px.size()), head_x, head_y} !== {1'b1, 4'd0, 8'd112, 7'd60})
            $display("FAIL wall_hit: got over=%b px=%0d (%0d,%0d) want over=1 px=0 (112,60)",
                     over, obs_px.size(), head_x, head_y);
        else pass_cnt++;
        do_step(2, 1, 0, ok);
        chk_cnt++;
        if ({over, busy, 4'(obs_px.size()), head_x, head_y, length} !==
            {1'b1, 1'b0, 4'd0, 8'd112, 7'd60, 8'd1})
            $display("FAIL wall_ignored: got over=%b busy=%b px=%0d (%0d,%0d) len=%0d want 1/0/0 (112,60) 1",
                     over, busy, obs_px.size(), head_x, head_y, length);
        else pass_cnt++;
    endtask

    task automatic test_self_hit();
        bit ok;
        int dseq[7] = '{1, 1, 1, 1, 2, 0, 3};
        do_restart();
        for (int s = 0; s < 7; s++) begin
            do_step(dseq[s], s < 4, 0, ok);
            model_step(dseq[s], s < 4);
            chk_cnt++;
            if (obs_word() !== exp_word())
                $display("FAIL selfhit_px: step %0d got %h want %h", s, obs_word(), exp_word());
            else pass_cnt++;
        end
        chk_cnt++;
        if ({over, head_x, head_y, length} !== {1'b1, 8'd83, 7'd59, 8'd5})
            $display("FAIL selfhit_end: got over=%b (%0d,%0d) len=%0d want over=1 (83,59) len=5",
                     over, head_x, head_y, length);
        else pass_cnt++;
    endtask

    task automatic test_reversal();
        bit ok;
        do_restart();
        do_step(0, 0, 0, ok);
        model_step(0, 0);
        chk_cnt++;
        if ({head_x, head_y, obs_word()} !== {8'd81, 7'd60, exp_word()})
            $display("FAIL reversal: got (%0d,%0d) px=%h want (81,60) px=%h", head_x, head_y, obs_word(), exp_word());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int held, waited;
        do_restart();
        model_step(1, 0);
        obs_px.delete(); obs_edge.delete();
        @(posedge clk); #1;
        px_ready = 1'b0; dir = 2'd1; step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!px_valid && waited < 50);
        held = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if ({px_valid, px_x, px_y, px_colour} === {1'b1, exp_px[0]}) held++;
        end
        chk_cnt++;
        if (held !== 3) $display("FAIL bp_erase_hold: got %0d stable cycles want 3", held);
        else pass_cnt++;
        @(posedge clk); #1 px_ready = 1'b1;
        @(posedge clk); #1 px_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({px_valid, px_x, px_y, px_colour} === {1'b1, exp_px[1]}) held++;
        end
        chk_cnt++;
        if (held !== 5) $display("FAIL bp_draw_hold: got %0d stable cycles want 5", held);
        else pass_cnt++;
        @(posedge clk); #1 px_ready = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (busy && waited < 50);
        chk_cnt++;
        if (obs_word() !== exp_word())
            $display("FAIL bp_handshakes: got %h want %h", obs_word(), exp_word());
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        bit ok;
        int d;
        int bad = 0;
        do_restart();
        for (int s = 0; s < 128; s++) begin
            if (s < 32) d = 1;
            else if (s == 32) d = 3;
            else if (s < 97) d = 0;
            else if (s == 97) d = 3;
            else d = 1;
            do_step(d, 1, 0, ok);
            model_step(d, 1);
            chk_cnt++;
            if (obs_word() !== exp_word()) begin
                $display("FAIL sat_px: step %0d got %h want %h", s, obs_word(), exp_word());
                bad++;
            end else pass_cnt++;
            if (bad > 5) break;
        end
        chk_cnt++;
        if ({length, over, 4'(obs_px.size()), obs_px[0][2:0]} !== {8'd128, 1'b0, 4'd2, 3'b111})
            $display("FAIL sat_end: got len=%0d over=%b px=%0d want len=128 over=0 px=2 with erase first",
                     length, over, obs_px.size());
        else pass_cnt++;
    endtask

    task automatic test_restart_mid();
        bit ok;
        int waited;
        do_restart();
        obs_px.delete(); obs_edge.delete();
        @(posedge clk); #1;
        px_ready = 1'b0; dir = 2'd1; step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!px_valid && waited < 50);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({px_valid, busy, head_x, head_y, length, 4'(obs_px.size())} !==
            {1'b0, 1'b0, 8'd80, 7'd60, 8'd1, 4'd0})
            $display("FAIL restart_mid: got v=%b busy=%b (%0d,%0d) len=%0d px=%0d want 0/0 (80,60) 1 0",
                     px_valid, busy, head_x, head_y, length, obs_px.size());
        else pass_cnt++;
        px_ready = 1'b1;
        model_reset();
        do_step(1, 0, 0, ok);
        model_step(1, 0);
        chk_cnt++;
        if (obs_word() !== exp_word())
            $display("FAIL restart_resume: got %h want %h", obs_word(), exp_word());
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit ok;
        int d;
        bit g;
        int bad = 0;
        do_restart();
        for (int s = 0; s < 150; s++) begin
            d = $urandom_range(0, 3);
            g = ($urandom_range(0, 3) == 0);
            do_step(d, g, 1, ok);
            model_step(d, g);
            chk_cnt++;
            if (ok !== 1'b1 || obs_word() !== exp_word()) begin
                $display("FAIL rand_px: step %0d ok=%b got %h want %h", s, ok, obs_word(), exp_word());
                bad++;
            end else pass_cnt++;
            chk_cnt++;
            if ({head_x, head_y, length, over} !== model_state()) begin
                $display("FAIL rand_state: step %0d got %h want %h", s, {head_x, head_y, length, over}, model_state());
                bad++;
            end else pass_cnt++;
            if (bad > 5) break;
            if (m_over) do_restart();
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_wall();
        test_self_hit();
        test_reversal();
        test_backpressure();
        test_saturate();
        test_restart_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
